// File: rtl/wspr_pkg.sv
// Shared types and constants for the WSPR symbol scheduler and TX-side blocks.
package wspr_pkg;

  localparam int WSPR_NSYM = 162;
  localparam int PHI_W     = 32;

  typedef logic [1:0] sym_t;

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

endpackage

// File: rtl/wspr_sym_sched_if.sv
// Control/NCO-side signal bundle of wspr_sym_sched; loop_en exists only with WSPR_SCHED_LOOP_EN.
interface wspr_sym_sched_if;
  import wspr_pkg::*;

  logic [PHI_W-1:0] rx_phi;
  logic [PHI_W-1:0] base_phi;
  logic [PHI_W-1:0] tone_step;
  logic             sym_wr;
  logic [7:0]       sym_addr;
  sym_t             sym_data;
  logic             start;
  logic             abort;
`ifdef WSPR_SCHED_LOOP_EN
  logic             loop_en;
`endif
  logic [PHI_W-1:0] phi;
  logic             busy;
  logic [7:0]       sym_idx;
  logic             done;

`ifdef WSPR_SCHED_LOOP_EN
  modport master (
    output rx_phi, base_phi, tone_step, sym_wr, sym_addr, sym_data, start, abort, loop_en,
    input  phi, busy, sym_idx, done
  );
  modport slave (
    input  rx_phi, base_phi, tone_step, sym_wr, sym_addr, sym_data, start, abort, loop_en,
    output phi, busy, sym_idx, done
  );
`else
  modport master (
    output rx_phi, base_phi, tone_step, sym_wr, sym_addr, sym_data, start, abort,
    input  phi, busy, sym_idx, done
  );
  modport slave (
    input  rx_phi, base_phi, tone_step, sym_wr, sym_addr, sym_data, start, abort,
    output phi, busy, sym_idx, done
  );
`endif

endinterface

// File: rtl/wspr_tone_calc.sv
// Combinational 4-FSK tone word: base + sym*step, modulo 2^PHI_W.
module wspr_tone_calc
  import wspr_pkg::*;
(
  input  logic [PHI_W-1:0] base,
  input  logic [PHI_W-1:0] step,
  input  sym_t             sym,
  output logic [PHI_W-1:0] phi
);

  logic [PHI_W-1:0] off2;
  logic [PHI_W-1:0] off1;

  // sym*step built from a shift and an add so no multiplier is inferred
  always_comb begin
    off2 = sym[1] ? {step[PHI_W-2:0], 1'b0} : '0;
    off1 = sym[0] ? step : '0;
    phi  = base + off2 + off1;
  end

endmodule

// File: rtl/wspr_sym_sched.sv
// WSPR symbol scheduler: drives the NCO frequency word, rx pass-through when idle, 4-FSK table when transmitting.
// Optional macro WSPR_SCHED_LOOP_EN adds loop_en for gapless repeated transmissions.
module wspr_sym_sched
  import wspr_pkg::*;
#(
  parameter int SYM_LEN = 52428800,
  parameter int NSYM    = WSPR_NSYM,
  parameter int CNT_W   = 26
) (
  input  logic             clk,
  input  logic             rst,
  wspr_sym_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [7:0]       LAST_IDX = 8'(NSYM - 1);
  localparam logic [7:0]       ADDR_LIM = 8'(NSYM);

  state_t           state_q, state_d;
  logic [PHI_W-1:0] phi_q, phi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lat_en;

  logic [PHI_W-1:0] base_q, step_q;
  sym_t             tbl [NSYM];

  logic             use_in;
  logic [7:0]       rd_idx;
  sym_t             rd_sym;
  logic [PHI_W-1:0] calc_base, calc_step, tone_phi;
  logic             loop_req;

`ifdef WSPR_SCHED_LOOP_EN
  assign loop_req = bus.loop_en;
`else
  assign loop_req = 1'b0;
`endif

  // Tone source: fresh inputs and symbol 0 when (re)starting, latched words and the next symbol otherwise.
  always_comb begin
    use_in    = !(state_q == TX && idx_q < LAST_IDX);
    rd_idx    = use_in ? 8'd0 : idx_q + 8'd1;
    rd_sym    = tbl[rd_idx];
    calc_base = use_in ? bus.base_phi  : base_q;
    calc_step = use_in ? bus.tone_step : step_q;
  end

  wspr_tone_calc u_tone (
    .base (calc_base),
    .step (calc_step),
    .sym  (rd_sym),
    .phi  (tone_phi)
  );

  always_comb begin
    state_d = state_q;
    phi_d   = phi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lat_en  = 1'b0;
    case (state_q)
      IDLE: begin
        phi_d  = bus.rx_phi;
        busy_d = 1'b0;
        idx_d  = '0;
        cnt_d  = '0;
        if (bus.start && !bus.abort) begin
          state_d = TX;
          busy_d  = 1'b1;
          lat_en  = 1'b1;
          phi_d   = tone_phi;
        end
      end
      TX: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          phi_d   = bus.rx_phi;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q < LAST_IDX) begin
            idx_d = idx_q + 8'd1;
            phi_d = tone_phi;
          end else if (loop_req) begin
            idx_d  = '0;
            lat_en = 1'b1;
            done_d = 1'b1;
            phi_d  = tone_phi;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            phi_d   = bus.rx_phi;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      phi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phi_q   <= phi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Table and latched tone words carry no reset; the table is frozen while transmitting.
  always_ff @(posedge clk) begin
    if (lat_en) begin
      base_q <= bus.base_phi;
      step_q <= bus.tone_step;
    end
    if (bus.sym_wr && !busy_q && bus.sym_addr < ADDR_LIM)
      tbl[bus.sym_addr] <= bus.sym_data;
  end

  assign bus.phi     = phi_q;
  assign bus.busy    = busy_q;
  assign bus.sym_idx = idx_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_wspr_sym_sched.sv
// Bench for wspr_sym_sched with a short symbol period; vector table, directed sequences and random traffic vs a time-based model.
module tb_wspr_sym_sched;
  import wspr_pkg::*;

  localparam int SL = 16;
  localparam int NS = 162;

  logic clk = 1'b0;
  logic rst;
  logic loop_drv;
  always #5 clk = ~clk;

  wspr_sym_sched_if bus ();

`ifdef WSPR_SCHED_LOOP_EN
  assign bus.loop_en = loop_drv;
`endif

  wspr_sym_sched #(.SYM_LEN(SL), .NSYM(NS), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position in the transmission is a cycle count since start.
  bit          m_act = 0;
  int          m_t = 0;
  logic [31:0] m_base = '0, m_step = '0;
  logic [1:0]  m_tbl [NS];
  logic [31:0] e_phi = '0;
  logic        e_busy = 0, e_done = 0;
  logic [7:0]  e_idx = '0;

  typedef struct {
    logic [1:0]  s;
    logic [31:0] base;
    logic [31:0] step;
    logic [31:0] exp;
  } tv_t;
  tv_t tv [7];

  function automatic logic [31:0] tone(int i);
    return m_base + 32'(m_tbl[i]) * m_step;
  endfunction

  task automatic finish_tx();
    m_act  = 0;
    e_busy = 0;
    e_done = 1;
    e_idx  = '0;
    e_phi  = bus.rx_phi;
  endtask

  task automatic model_edge();
    bit was = m_act;
    if (!rst) begin
      m_act = 0; e_phi = '0; e_busy = 0; e_idx = '0; e_done = 0;
    end else begin
      e_done = 0;
      if (m_act) begin
        if (bus.abort) finish_tx();
        else begin
          m_t++;
          if (m_t == NS * SL) begin
            if (loop_drv) begin
              m_t = 0; m_base = bus.base_phi; m_step = bus.tone_step;
              e_done = 1; e_idx = '0; e_phi = tone(0);
            end else finish_tx();
          end else begin
            e_idx = 8'(m_t / SL);
            e_phi = tone(m_t / SL);
          end
        end
      end else begin
        e_phi = bus.rx_phi;
        if (bus.start && !bus.abort) begin
          m_act = 1; m_t = 0; m_base = bus.base_phi; m_step = bus.tone_step;
          e_busy = 1; e_idx = '0; e_phi = tone(0);
        end
      end
    end
    if (!was && bus.sym_wr && int'(bus.sym_addr) < NS) m_tbl[bus.sym_addr] = bus.sym_data;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("phi", bus.phi, e_phi);
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("sym_idx", 32'(bus.sym_idx), 32'(e_idx));
    chk("done", 32'(bus.done), 32'(e_done));
  endtask

  logic [31:0] seq_exp [4];
  int nb, nd;

  initial begin
    tv[0] = '{2'd3, 32'hFFFF_FF00, 32'h0000_0100, 32'h0000_0200};
    tv[1] = '{2'd0, 32'h1000_0000, 32'h0000_0100, 32'h1000_0000};
    tv[2] = '{2'd1, 32'h1000_0000, 32'h0000_0100, 32'h1000_0100};
    tv[3] = '{2'd2, 32'h1000_0000, 32'h0000_0100, 32'h1000_0200};
    tv[4] = '{2'd3, 32'h1000_0000, 32'h0000_0100, 32'h1000_0300};
    tv[5] = '{2'd2, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tv[6] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    seq_exp[0] = 32'h1000_0000; seq_exp[1] = 32'h1000_0100;
    seq_exp[2] = 32'h1000_0200; seq_exp[3] = 32'h1000_0300;

    rst = 0; loop_drv = 0;
    bus.rx_phi = 32'h1234_5678; bus.base_phi = '0; bus.tone_step = '0;
    bus.sym_wr = 0; bus.sym_addr = '0; bus.sym_data = '0; bus.start = 0; bus.abort = 0;

    // reset and idle pass-through
    step(); step();
    chk("rst_phi", bus.phi, 32'h0);
    rst = 1;
    step();
    chk("idle_phi", bus.phi, 32'h1234_5678);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    for (int i = 0; i < NS; i++) begin
      bus.sym_wr = 1; bus.sym_addr = 8'(i); bus.sym_data = 2'(i % 4);
      step();
    end
    bus.sym_wr = 0;

    // tone arithmetic vectors
    for (int k = 0; k < 7; k++) begin
      bus.sym_wr = 1; bus.sym_addr = 8'd0; bus.sym_data = tv[k].s;
      step();
      bus.sym_wr = 0; bus.base_phi = tv[k].base; bus.tone_step = tv[k].step; bus.start = 1;
      step();
      bus.start = 0;
      chk("tone_vec", bus.phi, tv[k].exp);
      bus.abort = 1;
      step();
      bus.abort = 0;
      chk("tone_abort_done", 32'(bus.done), 32'h1);
    end
    bus.sym_wr = 1; bus.sym_addr = 8'd0; bus.sym_data = 2'd0;
    step();
    bus.sym_wr = 0;

    // full transmission
    bus.rx_phi = 32'hCAFE_0001; bus.base_phi = 32'h1000_0000; bus.tone_step = 32'h0000_0100;
    bus.start = 1; nb = 0; nd = 0;
    for (int c = 0; c < 2600; c++) begin
      step();
      bus.start = 0;
      if (bus.busy) nb++;
      if (bus.done) nd++;
      if (c < 64 && c % 16 == 0) chk("seq_phi", bus.phi, seq_exp[c / 16]);
      if (c == 2592) chk("seq_end_phi", bus.phi, 32'hCAFE_0001);
    end
    chk("busy_cycles", 32'(nb), 32'd2592);
    chk("done_pulses", 32'(nd), 32'd1);

    // abort 40 cycles in, with a simultaneous start
    bus.start = 1;
    step();
    bus.start = 0;
    repeat (39) step();
    bus.abort = 1; bus.start = 1;
    step();
    bus.abort = 0; bus.start = 0;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h1);
    chk("abort_phi", bus.phi, 32'hCAFE_0001);
    chk("abort_idx", 32'(bus.sym_idx), 32'h0);
    step();
    chk("abort_stay_idle", 32'(bus.busy), 32'h0);
    chk("abort_done_once", 32'(bus.done), 32'h0);

    // table protection and start ignored during TX
    for (int c = 0; c < 2600; c++) begin
      bus.start    = (c == 0 || c == 30);
      bus.sym_wr   = (c == 20 || c == 21);
      bus.sym_addr = (c == 20) ? 8'd5 : 8'd200;
      bus.sym_data = (c == 20) ? 2'd2 : 2'd3;
      step();
      if (c == 80) chk("prot_sym5", bus.phi, 32'h1000_0100);
      if (c == 100) chk("prot_idx", 32'(bus.sym_idx), 32'd6);
    end
    bus.start = 0; bus.sym_wr = 0;

`ifdef WSPR_SCHED_LOOP_EN
    loop_drv = 1; bus.start = 1;
    for (int c = 0; c < 2600; c++) begin
      step();
      bus.start = 0;
      if (c == 2592) begin
        chk("loop_idx", 32'(bus.sym_idx), 32'h0);
        chk("loop_busy", 32'(bus.busy), 32'h1);
        chk("loop_done", 32'(bus.done), 32'h1);
      end
      if (c == 2593) chk("loop_done_once", 32'(bus.done), 32'h0);
    end
    loop_drv = 0; bus.abort = 1;
    step();
    bus.abort = 0;
`endif

    // random traffic
    for (int n = 0; n < 14000; n++) begin
      rst           = ($urandom_range(0, 4999) != 0);
      bus.rx_phi    = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        bus.base_phi  = $urandom;
        bus.tone_step = $urandom;
      end
      bus.sym_wr    = ($urandom_range(0, 7) == 0);
      bus.sym_addr  = 8'($urandom_range(0, 255));
      bus.sym_data  = 2'($urandom_range(0, 3));
      bus.start     = ($urandom_range(0, 63) == 0);
      bus.abort     = ($urandom_range(0, 1499) == 0);
`ifdef WSPR_SCHED_LOOP_EN
      loop_drv      = ($urandom_range(0, 1) == 0);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wspr_sym_sched.md
Name: wspr_sym_sched

Overview:
- Symbol scheduler and phase-word controller for the WSPR NCO/mixer datapath. It drives the 32-bit `phi` frequency word consumed by the NCO.
- While idle it passes through the receive tuning word.
- While transmitting it steps through a 162-symbol 4-FSK table at the WSPR symbol rate, producing `phi = base + sym*tone_step`.
- It sits between the control/register interface and the NCO/mixer.

Parameters:
- SYM_LEN, 52428800, clock cycles per symbol (76.8 MHz * 8192/12000 s).
- NSYM, 162, number of symbols per transmission.
- CNT_W, 26, width of the symbol-period counter; must satisfy 2^CNT_W >= SYM_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- rx_phi  in  32  receive tuning word, passed through when idle.
- base_phi  in  32  tone-0 frequency word; latched at start.
- tone_step  in  32  tone spacing word; latched at start.
- sym_wr  in  1  symbol-table write strobe.
- sym_addr  in  8  symbol-table write address, 0..NSYM-1.
- sym_data  in  2  symbol value 0..3.
- start  in  1  single-cycle request to begin transmission.
- abort  in  1  single-cycle request to stop transmission.
- phi  out  32  registered frequency word to the NCO.
- busy  out  1  high while in state TX.
- sym_idx  out  8  index of the symbol currently being sent.
- done  out  1  one-cycle pulse on completion or abort.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; phi=0, busy=0, sym_idx=0, done=0; period counter=0.
  - Symbol table contents are not reset. Reset mid-TX ends the transmission immediately, with no done pulse.
- Symbol table:
  - NSYM x 2-bit register array, written on sym_wr when sym_addr<NSYM.
  - Writes with sym_addr>=NSYM are ignored.
  - Writes while busy=1 are ignored.
- State IDLE:
  - phi <= rx_phi on every cycle (1-cycle latency).
  - start=1 and abort=0 -> latch base_phi and tone_step, sym_idx<=0, counter<=0, phi<=base+f(table[0]), busy<=1, go to TX.
- State TX:
  - counter increments every cycle.
  - When counter==SYM_LEN-1: counter<=0.
    - If sym_idx<NSYM-1: sym_idx++ and phi<=base+f(table[sym_idx+1]). phi changes on the same edge that sym_idx changes.
    - Else: go to IDLE, busy<=0, done<=1, sym_idx<=0, phi<=rx_phi.
  - Each symbol occupies exactly SYM_LEN cycles of phi. Total TX duration is NSYM*SYM_LEN cycles.
- Tone arithmetic: f(s) = (s[1] ? step<<1 : 0) + (s[0] ? step : 0). The sum with base is modulo 2^32; wrap-around is silent.
- abort:
  - Has priority over start and over symbol advance.
  - abort in TX -> next edge: IDLE, busy=0, done=1, phi<=rx_phi, sym_idx<=0.
  - abort in IDLE is a no-op (no done pulse).
- start while in TX is ignored.
- start and abort asserted together in IDLE: stay in IDLE.
- done is high for exactly one cycle, otherwise 0.
- base_phi and tone_step changes during TX have no effect until the next start.

Optional Feature:
- Macro: WSPR_SCHED_LOOP_EN.
- Defined: adds input loop_en (1 bit).
  - If loop_en=1 at the final symbol boundary, the block restarts at symbol 0 with no idle gap and re-latches base_phi/tone_step.
  - done still pulses for one cycle, and busy stays 1.
  - abort behaves as without the macro.
- Undefined: no loop_en port; behaviour exactly as above.

Decomposition:
- Package wspr_pkg holds:
  - state typedef enum {IDLE, TX};
  - localparams WSPR_NSYM=162 and PHI_W=32;
  - symbol typedef logic [1:0].
- Sub-module wspr_tone_calc (combinational base + s*step, modulo 2^32) is natural. It is shared with future TX-side blocks.

Test Plan:
- Reset/idle pass-through: rst=0 then 1, rx_phi=32'h1234_5678 -> phi=0 during reset; phi=32'h1234_5678 one cycle after release; busy=0.
- Full sequence, SYM_LEN=16, table[i]=i%4, base=32'h1000_0000, step=32'h0000_0100:
  - phi cycles through 1000_0000, 1000_0100, 1000_0200, 1000_0300, 16 cycles each.
  - sym_idx counts 0..161.
  - busy high for exactly 2592 cycles, then done pulses once and phi returns to rx_phi.
- Wrap: base=32'hFFFF_FF00, step=32'h100, symbol 3 -> phi=32'h0000_0200.
- Abort at cycle 40 of TX -> next cycle busy=0, done=1, phi=rx_phi, sym_idx=0. start in the same cycle as abort is ignored.
- Protection:
  - sym_wr to addr 5 with data 2 during TX does not alter the sent symbol 5.
  - sym_wr to addr 200 alters nothing.
  - start during TX does not restart the sequence (sym_idx keeps advancing).
- Loop (WSPR_SCHED_LOOP_EN, loop_en=1): after symbol 161, sym_idx=0 on the next cycle, busy stays 1, done pulses once.
